// File: rtl/hvac_sequencer_if.sv
// Thermostat-side bundle of the HVAC sequencer: the two request levels
// coming in and the equipment drives plus status going out.
interface hvac_sequencer_if;
  logic       heat_req;
  logic       cool_req;
  logic       heater_en;
  logic       compressor_en;
  logic       fan_en;
  logic       lockout;
  logic [2:0] state;

  // The thermostat stage (or a bench) drives the requests and watches the drives
  modport master (
    output heat_req,
    output cool_req,
    input  heater_en,
    input  compressor_en,
    input  fan_en,
    input  lockout,
    input  state
  );

  // The sequencer consumes the requests and owns every drive
  modport slave (
    input  heat_req,
    input  cool_req,
    output heater_en,
    output compressor_en,
    output fan_en,
    output lockout,
    output state
  );
endinterface

// File: rtl/hvac_sequencer.sv
// HVAC equipment sequencer.
// Runs the blower ahead of the heater or compressor, holds the element on for
// a minimum run time, lets the blower purge afterwards and then enforces an
// anti-short-cycle lockout before another call is accepted. Reset lands in the
// lockout so a power glitch cannot restart the compressor early.
module hvac_sequencer #(
  parameter int unsigned FAN_LEAD = 2,
  parameter int unsigned MIN_ON   = 5,
  parameter int unsigned FAN_LAG  = 3,
  parameter int unsigned MIN_OFF  = 4,
  parameter int unsigned CW       = 16
) (
  input logic             clk,
  input logic             reset,
  hvac_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FAN_LEAD = 3'd1,
    S_HEAT_RUN = 3'd2,
    S_COOL_RUN = 3'd3,
    S_FAN_LAG  = 3'd4,
    S_LOCKOUT  = 3'd5
  } state_t;

  // Last counter value of each timed phase: the counter is 0 during the first
  // cycle in a state, so a phase of N cycles ends on the edge where it reads N-1.
  localparam logic [CW-1:0] LEAD_LAST = CW'(FAN_LEAD - 1);
  localparam logic [CW-1:0] ON_LAST   = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] LAG_LAST  = CW'(FAN_LAG - 1);
  localparam logic [CW-1:0] OFF_LAST  = CW'(MIN_OFF - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_modeCool;
  logic          r_heaterEn;
  logic          r_compressorEn;
  logic          r_fanEn;
  logic          r_lockout;

  state_t        w_nextState;
  logic          w_nextModeCool;
  logic          w_heatValid;
  logic          w_coolValid;
  logic          w_modeValid;

  // Conflicting or absent requests are treated as no call at all
  assign w_heatValid = bus.heat_req & ~bus.cool_req;
  assign w_coolValid = bus.cool_req & ~bus.heat_req;
  assign w_modeValid = r_modeCool ? w_coolValid : w_heatValid;

  // Transition rules; a run only ends once the minimum on-time is served and
  // the call for the latched mode has gone (an opposite call counts as gone)
  always_comb begin
    w_nextState    = r_state;
    w_nextModeCool = r_modeCool;
    case (r_state)
      S_IDLE: begin
        if (w_heatValid) begin
          w_nextState    = S_FAN_LEAD;
          w_nextModeCool = 1'b0;
        end else if (w_coolValid) begin
          w_nextState    = S_FAN_LEAD;
          w_nextModeCool = 1'b1;
        end
      end
      S_FAN_LEAD: begin
        if (!w_modeValid) begin
          w_nextState = S_IDLE;
        end else if (r_count >= LEAD_LAST) begin
          w_nextState = r_modeCool ? S_COOL_RUN : S_HEAT_RUN;
        end
      end
      S_HEAT_RUN, S_COOL_RUN: begin
        if ((r_count >= ON_LAST) && !w_modeValid) begin
          w_nextState = S_FAN_LAG;
        end
      end
      S_FAN_LAG: begin
        if (r_count >= LAG_LAST) begin
          w_nextState = S_LOCKOUT;
        end
      end
      S_LOCKOUT: begin
        if (r_count >= OFF_LAST) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_LOCKOUT;
      end
    endcase
  end

  // State, dwell counter, mode and drives all register together so every drive
  // switches on the same edge as the state it belongs to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_LOCKOUT;
      r_count        <= '0;
      r_modeCool     <= 1'b0;
      r_heaterEn     <= 1'b0;
      r_compressorEn <= 1'b0;
      r_fanEn        <= 1'b0;
      r_lockout      <= 1'b1;
    end else begin
      r_state    <= w_nextState;
      r_modeCool <= w_nextModeCool;
      if (w_nextState != r_state) begin
        r_count <= '0;
      end else if (r_count != CNT_MAX) begin
        r_count <= r_count + CNT_ONE;
      end
      r_heaterEn     <= (w_nextState == S_HEAT_RUN);
      r_compressorEn <= (w_nextState == S_COOL_RUN);
      r_fanEn        <= (w_nextState == S_FAN_LEAD) || (w_nextState == S_HEAT_RUN) ||
                        (w_nextState == S_COOL_RUN) || (w_nextState == S_FAN_LAG);
      r_lockout      <= (w_nextState == S_LOCKOUT);
    end
  end

  assign bus.heater_en     = r_heaterEn;
  assign bus.compressor_en = r_compressorEn;
  assign bus.fan_en        = r_fanEn;
  assign bus.lockout       = r_lockout;
  assign bus.state         = r_state;

  // Equipment-safety invariants: never both elements, never an element without airflow
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(r_heaterEn && r_compressorEn));
      assert (!((r_heaterEn || r_compressorEn) && !r_fanEn));
    end
  end

endmodule

// File: tb/tb_hvac_sequencer.sv
// Self-checking bench for hvac_sequencer: directed scenarios followed by
// randomly held request patterns, all compared against a phase/dwell model.
module tb_hvac_sequencer;

  localparam int FAN_LEAD = 2;
  localparam int MIN_ON   = 5;
  localparam int FAN_LAG  = 3;
  localparam int MIN_OFF  = 4;

  localparam int P_IDLE     = 0;
  localparam int P_FAN_LEAD = 1;
  localparam int P_HEAT_RUN = 2;
  localparam int P_COOL_RUN = 3;
  localparam int P_FAN_LAG  = 4;
  localparam int P_LOCKOUT  = 5;

  logic clk;
  logic reset;

  hvac_sequencer_if bus ();

  hvac_sequencer #(
    .FAN_LEAD(FAN_LEAD),
    .MIN_ON  (MIN_ON),
    .FAN_LAG (FAN_LAG),
    .MIN_OFF (MIN_OFF),
    .CW      (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: current phase, cycles still owed in a timed phase,
  // cycles already served in a run, and whether the call being served is cooling
  int mPhase;
  int mLeft;
  int mServed;
  bit mCool;

  int heatOnLen = 0;
  int coolOnLen = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPhase  = P_LOCKOUT;
    mLeft   = MIN_OFF;
    mServed = 0;
    mCool   = 1'b0;
  endtask

  task automatic modelStep();
    bit hv;
    bit cv;
    bit want;
    hv   = bus.heat_req && !bus.cool_req;
    cv   = bus.cool_req && !bus.heat_req;
    want = mCool ? cv : hv;
    case (mPhase)
      P_IDLE: begin
        if (hv || cv) begin
          mCool  = cv;
          mPhase = P_FAN_LEAD;
          mLeft  = FAN_LEAD;
        end
      end
      P_FAN_LEAD: begin
        if (!want) begin
          mPhase = P_IDLE;
        end else begin
          mLeft--;
          if (mLeft == 0) begin
            mPhase  = mCool ? P_COOL_RUN : P_HEAT_RUN;
            mServed = 0;
          end
        end
      end
      P_HEAT_RUN, P_COOL_RUN: begin
        mServed++;
        if (mServed >= MIN_ON && !want) begin
          mPhase = P_FAN_LAG;
          mLeft  = FAN_LAG;
        end
      end
      P_FAN_LAG: begin
        mLeft--;
        if (mLeft == 0) begin
          mPhase = P_LOCKOUT;
          mLeft  = MIN_OFF;
        end
      end
      default: begin
        mLeft--;
        if (mLeft == 0) mPhase = P_IDLE;
      end
    endcase
  endtask

  task automatic checkAll(input string tag);
    bit expFan;
    expFan = (mPhase == P_FAN_LEAD) || (mPhase == P_HEAT_RUN) ||
             (mPhase == P_COOL_RUN) || (mPhase == P_FAN_LAG);
    checkOutput({tag, "_state"}, 32'(bus.state), 32'(mPhase));
    checkOutput({tag, "_heater"}, 32'(bus.heater_en), 32'(mPhase == P_HEAT_RUN));
    checkOutput({tag, "_compressor"}, 32'(bus.compressor_en), 32'(mPhase == P_COOL_RUN));
    checkOutput({tag, "_fan"}, 32'(bus.fan_en), 32'(expFan));
    checkOutput({tag, "_lockout"}, 32'(bus.lockout), 32'(mPhase == P_LOCKOUT));
    checkOutput({tag, "_bothElements"}, 32'(bus.heater_en && bus.compressor_en), 32'd0);
    checkOutput({tag, "_elementNoFan"},
                32'((bus.heater_en || bus.compressor_en) && !bus.fan_en), 32'd0);
  endtask

  // Measures each element on-period independently of the model
  task automatic trackOnTime();
    if (bus.heater_en === 1'b1) begin
      heatOnLen++;
    end else if (heatOnLen > 0) begin
      checkOutput("minOnHeat", 32'(heatOnLen >= MIN_ON), 32'd1);
      heatOnLen = 0;
    end
    if (bus.compressor_en === 1'b1) begin
      coolOnLen++;
    end else if (coolOnLen > 0) begin
      checkOutput("minOnCool", 32'(coolOnLen >= MIN_ON), 32'd1);
      coolOnLen = 0;
    end
  endtask

  // One clock: model advances on the rising edge, outputs compared on the falling edge
  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) modelReset();
    else modelStep();
    @(negedge clk);
    checkAll(tag);
    trackOnTime();
  endtask

  task automatic applyStimulus(input bit heat, input bit cool);
    bus.heat_req = heat;
    bus.cool_req = cool;
  endtask

  initial begin
    int holdLeft;
    int pick;
    int waited;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0);
    modelReset();
    $display("[TB] start");

    // Reset held over a couple of edges with a heating call already present
    repeat (2) @(negedge clk);
    checkAll("reset");

    // Release: lockout 4 cycles, idle 1, fan lead 2, then heater
    reset = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick("req031");
      if (t == 6) checkOutput("req031_leadNoHeater", 32'(bus.heater_en), 32'd0);
    end
    checkOutput("req031_heaterOn", 32'(bus.heater_en), 32'd1);

    // Call dropped one cycle after heater rises: heater holds its minimum on-time
    tick("req032");
    applyStimulus(1'b0, 1'b0);
    repeat (3) tick("req032");
    checkOutput("req032_heaterLast", 32'(bus.heater_en), 32'd1);
    tick("req032");
    checkOutput("req032_heaterOff", 32'(bus.heater_en), 32'd0);
    checkOutput("req032_fanLag", 32'(bus.fan_en), 32'd1);
    repeat (7) tick("req032");
    checkOutput("req032_idle", 32'(bus.state), 32'(P_IDLE));

    // Cooling run interrupted by an opposite call: full purge and lockout before heating
    applyStimulus(1'b0, 1'b1);
    repeat (3) tick("req033");
    checkOutput("req033_compressorOn", 32'(bus.compressor_en), 32'd1);
    applyStimulus(1'b1, 1'b0);
    repeat (15) tick("req033");
    checkOutput("req033_heatRun", 32'(bus.state), 32'(P_HEAT_RUN));
    applyStimulus(1'b0, 1'b0);
    repeat (15) tick("req033");

    // Conflicting requests are no call
    applyStimulus(1'b1, 1'b1);
    repeat (5) tick("req035");
    checkOutput("req035_idle", 32'(bus.state), 32'(P_IDLE));

    // Single-cycle cooling pulse aborts fan lead straight back to idle
    applyStimulus(1'b0, 1'b1);
    tick("req034");
    checkOutput("req034_lead", 32'(bus.state), 32'(P_FAN_LEAD));
    applyStimulus(1'b0, 1'b0);
    tick("req034");
    checkOutput("req034_backIdle", 32'(bus.state), 32'(P_IDLE));
    repeat (5) tick("req034");

    // Randomly held request patterns, including conflicts and short glitches
    holdLeft = 0;
    for (int c = 0; c < 400; c++) begin
      if (holdLeft == 0) begin
        pick = int'($urandom_range(0, 9));
        if (pick < 4)       applyStimulus(1'b1, 1'b0);
        else if (pick < 8)  applyStimulus(1'b0, 1'b1);
        else if (pick == 8) applyStimulus(1'b1, 1'b1);
        else                applyStimulus(1'b0, 1'b0);
        holdLeft = int'($urandom_range(1, 14));
      end
      holdLeft--;
      tick("random");
    end

    // Asynchronous reset in the middle of a heating run
    applyStimulus(1'b1, 1'b0);
    waited = 0;
    while (bus.state !== 3'(P_HEAT_RUN) && waited < 60) begin
      tick("req036_wait");
      waited++;
    end
    checkOutput("req036_reachedHeat", 32'(bus.state), 32'(P_HEAT_RUN));
    #2;
    reset = 1'b1;
    #1;
    checkOutput("req036_state", 32'(bus.state), 32'(P_LOCKOUT));
    checkOutput("req036_heater", 32'(bus.heater_en), 32'd0);
    checkOutput("req036_fan", 32'(bus.fan_en), 32'd0);
    checkOutput("req036_lockout", 32'(bus.lockout), 32'd1);
    modelReset();
    heatOnLen = 0;
    coolOnLen = 0;
    tick("req036_held");
    reset = 1'b0;
    repeat (12) tick("req036_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
